// File: rtl/one_wire_pkg.sv
// Constants shared by the 1-wire bridge command unpacker and response packer.
package one_wire_pkg;

  localparam int HDR_LEN_STAT = 0;
  localparam int HDR_FCMD     = 1;
  localparam int HDR_ADDR_LO  = 2;
  localparam int HDR_ADDR_HI  = 3;

  localparam int MAX_PAYLOAD  = 31;

  localparam int PRESENCE_BIT = 1;
  localparam int CRC_OK_BIT   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_PUSH,
    ST_FINISH
  } resp_state_e;

  function automatic logic [7:0] stat_byte(input logic [5:0] len,
                                           input logic presence,
                                           input logic crc_ok);
    logic [7:0] b;
    b = {len, 2'b00};
    b[PRESENCE_BIT] = presence;
    b[CRC_OK_BIT]   = crc_ok;
    return b;
  endfunction

endpackage

// File: rtl/one_wire_resp_ctrl.sv
// Packs a 1-wire transaction result (4-byte header + optional BRAM payload) into the TX byte FIFO.
// Header at done+1..done+4, each payload byte 3 cycles; pushes stall while fifo_full, done while busy is dropped.
module one_wire_resp_ctrl
  import one_wire_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int FIFO_WIDTH      = 8,
  parameter int BRAM_ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done,
  input  logic                       read_write,
  input  logic                       presence,
  input  logic                       crc_ok,
  input  logic [5:0]                 data_length,
  input  logic [7:0]                 Fun_cmd,
  input  logic [ADDRESS_WIDTH-1:0]   address,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic                       bram_rd_en,
  input  logic [FIFO_WIDTH-1:0]      bram_rd_data,
  input  logic                       fifo_full,
  output logic                       fifo_write_enable,
  output logic [FIFO_WIDTH-1:0]      fifo_write_data,
  output logic                       busy,
  output logic                       drop
);

  resp_state_e                state_q, state_d;
  logic [1:0]                 hdr_idx_q, hdr_idx_d;
  logic [BRAM_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [BRAM_ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [5:0]                 len_q, len_d;
  logic                       pres_q, pres_d;
  logic                       crc_q, crc_d;
  logic [7:0]                 fcmd_q, fcmd_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [FIFO_WIDTH-1:0]      hold_q, hold_d;
  logic                       busy_q, busy_d;
  logic                       drop_q, drop_d;
  logic [7:0]                 hdr_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hdr_idx_q   <= '0;
      idx_q       <= '0;
      bram_addr_q <= '0;
      len_q       <= '0;
      pres_q      <= 1'b0;
      crc_q       <= 1'b0;
      fcmd_q      <= '0;
      addr_q      <= '0;
      hold_q      <= '0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      idx_q       <= idx_d;
      bram_addr_q <= bram_addr_d;
      len_q       <= len_d;
      pres_q      <= pres_d;
      crc_q       <= crc_d;
      fcmd_q      <= fcmd_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    hdr_byte = '0;
    case (hdr_idx_q)
      2'(HDR_LEN_STAT): hdr_byte = stat_byte(len_q, pres_q, crc_q);
      2'(HDR_FCMD):     hdr_byte = fcmd_q;
      2'(HDR_ADDR_LO):  hdr_byte = addr_q[7:0];
      2'(HDR_ADDR_HI):  hdr_byte = addr_q[15:8];
      default:          hdr_byte = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    idx_d       = idx_q;
    bram_addr_d = bram_addr_q;
    len_d       = len_q;
    pres_d      = pres_q;
    crc_d       = crc_q;
    fcmd_d      = fcmd_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    busy_d      = busy_q;
    // Any done outside IDLE is discarded, including the FINISH cycle.
    drop_d      = done && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (done) begin
          pres_d    = presence;
          crc_d     = crc_ok;
          fcmd_d    = Fun_cmd;
          addr_d    = address;
          len_d     = !read_write ? 6'd0 :
                      (data_length > 6'(MAX_PAYLOAD)) ? 6'(MAX_PAYLOAD) : data_length;
          hdr_idx_d = '0;
          idx_d     = BRAM_ADDR_WIDTH'(1);
          busy_d    = 1'b1;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!fifo_full) begin
          if (hdr_idx_q == 2'(HDR_ADDR_HI)) begin
            if (len_q != 6'd0) begin
              bram_addr_d = idx_q;
              state_d     = ST_RD_REQ;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_FINISH;
            end
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        // Captured once; a stall in PUSH never causes a second BRAM read.
        hold_d  = bram_rd_data;
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (!fifo_full) begin
          if ({1'b0, idx_q} == len_q) begin
            busy_d  = 1'b0;
            state_d = ST_FINISH;
          end else begin
            idx_d       = idx_q + 1'b1;
            bram_addr_d = idx_q + 1'b1;
            state_d     = ST_RD_REQ;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign fifo_write_enable = ((state_q == ST_HDR) || (state_q == ST_PUSH)) && !fifo_full;
  assign fifo_write_data   = (state_q == ST_PUSH) ? hold_q :
                             (state_q == ST_HDR)  ? FIFO_WIDTH'(hdr_byte) : '0;
  assign bram_rd_en        = (state_q == ST_RD_REQ);
  assign bram_addr         = bram_addr_q;
  assign busy              = busy_q;
  assign drop              = drop_q;

endmodule
